vga_timing_engine: RTL

VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

---
 rtl/vga_timing_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_engine.sv
`default_nettype none
// ============================================================================
// vga_timing_engine : VGA raster counters, framebuffer addressing, and sync/colour
//                     output aligned to the framebuffer read latency.
// Revision 1.0
// ============================================================================
module vga_timing_engine #(
  parameter int HACTIVE     = 640,
  parameter int HFP         = 16,
  parameter int HSYNC       = 96,
  parameter int HBP         = 48,
  parameter int VACTIVE     = 480,
  parameter int VFP         = 10,
  parameter int VSYNC       = 2,
  parameter int VBP         = 33,
  parameter int RGB_W       = 3,
  parameter int ADDR_W      = 16,
  parameter int SCALE_SHIFT = 0,
  parameter int MEM_LATENCY = 1,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RGB_W-1:0]  pixel_rgb,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic [ADDR_W-1:0] pixel_address,
  output logic              frame_start,
  output logic              line_start
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
  // One spare count of headroom so every boundary constant (up to *TOTAL) fits.
  localparam int HW     = $clog2(HTOTAL + 1);
  localparam int VW     = $clog2(VTOTAL + 1);
  localparam int DEPTH  = 1 + MEM_LATENCY;

  localparam logic [HW-1:0]     H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0]     H_ACT    = HW'(HACTIVE);
  localparam logic [HW-1:0]     H_SS     = HW'(HACTIVE + HFP);
  localparam logic [HW-1:0]     H_SE     = HW'(HACTIVE + HFP + HSYNC);
  localparam logic [VW-1:0]     V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0]     V_ACT    = VW'(VACTIVE);
  localparam logic [VW-1:0]     V_SS     = VW'(VACTIVE + VFP);
  localparam logic [VW-1:0]     V_SE     = VW'(VACTIVE + VFP + VSYNC);
  localparam logic [VW-1:0]     V_MASK   = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(HACTIVE >> SCALE_SHIFT);
  localparam logic              HS_ON    = 1'(HSYNC_POL);
  localparam logic              VS_ON    = 1'(VSYNC_POL);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic frm;
    logic lin;
  } mark_t;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mark_t [DEPTH-1:0] pipe_q, pipe_d;
  mark_t             stage0, tap;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic              frame_q, frame_d;
  logic              line_q, line_d;

  always_comb begin
    stage0     = '0;
    stage0.act = (h_q < H_ACT) && (v_q < V_ACT);
    stage0.hs  = (h_q >= H_SS) && (h_q < H_SE);
    stage0.vs  = (v_q >= V_SS) && (v_q < V_SE);
    stage0.frm = (h_q == '0) && (v_q == '0);
    stage0.lin = (h_q == '0) && (v_q < V_ACT);
  end

  // Line and frame wraps resolve in the same clock as the pixel wrap.
  always_comb begin
    h_d   = h_q + 1'b1;
    v_d   = v_q;
    row_d = row_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d   = '0;
        row_d = '0;
      end else begin
        v_d = v_q + 1'b1;
        if ((v_q < V_ACT) && (((v_q + 1'b1) & V_MASK) == '0)) begin
          row_d = row_q + ROW_STEP;
        end
      end
    end
  end

  // Row base plus scaled column; the address holds through blanking.
  always_comb begin
    addr_d = addr_q;
    if (stage0.act) begin
      addr_d = row_q + ADDR_W'(h_q >> SCALE_SHIFT);
    end
  end

  always_comb begin
    pipe_d  = {pipe_q[DEPTH-2:0], stage0};
    tap     = pipe_q[DEPTH-1];
    rgb_d   = tap.act ? pixel_rgb : '0;
    hsync_d = tap.hs ? HS_ON : ~HS_ON;
    vsync_d = tap.vs ? VS_ON : ~VS_ON;
    frame_d = tap.frm;
    line_d  = tap.lin;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      pipe_q  <= '0;
      rgb_q   <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      frame_q <= 1'b0;
      line_q  <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
      line_q  <= line_d;
    end
  end

  assign vga_hsync     = hsync_q;
  assign vga_vsync     = vsync_q;
  assign vga_rgb       = rgb_q;
  assign pixel_address = addr_q;
  assign frame_start   = frame_q;
  assign line_start    = line_q;

endmodule
`default_nettype wire
